// File: rtl/sim_ctrl_gen.sv
// Simulation/system control: sequenced reset release, NUM_CH clock-enable tick channels, watchdog.
// Optional per-channel tick statistics output enabled by defining SIM_CTRL_STATS_EN.
module sim_ctrl_gen #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DIV_W     = 8,
  parameter int unsigned RST_HOLD  = 16,
  parameter int unsigned TIMEOUT_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH*DIV_W-1:0]   div_cfg,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic                      kick,
  input  logic                      done_i,
  input  logic [TIMEOUT_W-1:0]      timeout_lim,
  output logic                      rst_out_n,
  output logic [NUM_CH-1:0]         tick_o,
  output logic [1:0]                state_o,
  output logic [TIMEOUT_W-1:0]      cyc_cnt_o,
  output logic                      done_o,
`ifdef SIM_CTRL_STATS_EN
  output logic [NUM_CH*16-1:0]      tick_cnt_o,
`endif
  output logic                      timeout_o
);

  localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RUN     = 2'd1,
    S_DONE    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t                          state;
  logic [HOLD_W-1:0]               hold_cnt;
  logic [NUM_CH-1:0][DIV_W-1:0]    ch_cnt;
  logic [NUM_CH-1:0][DIV_W-1:0]    ch_cnt_nxt;
  logic [NUM_CH-1:0]               tick_nxt;
  logic [TIMEOUT_W-1:0]            wd_cnt;
  logic [TIMEOUT_W-1:0]            wd_inc;
  logic                            wd_expire;
`ifdef SIM_CTRL_STATS_EN
  logic [NUM_CH-1:0][15:0]         tick_cnt;
  assign tick_cnt_o = tick_cnt;
`endif

  assign state_o = state;

  // Next-cycle channel counters/ticks and watchdog expiry, used only while in RUN.
  always_comb begin
    ch_cnt_nxt = '0;
    tick_nxt   = '0;
    wd_inc     = wd_cnt + TIMEOUT_W'(1);
    wd_expire  = (timeout_lim != '0) && !kick && (wd_inc == timeout_lim);
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_en[i]) begin
        if (ch_cnt[i] >= div_cfg[i*DIV_W +: DIV_W]) begin
          tick_nxt[i] = 1'b1;
        end else begin
          ch_cnt_nxt[i] = ch_cnt[i] + DIV_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_HOLD;
      hold_cnt  <= '0;
      ch_cnt    <= '0;
      wd_cnt    <= '0;
      rst_out_n <= 1'b0;
      tick_o    <= '0;
      cyc_cnt_o <= '0;
      done_o    <= 1'b0;
      timeout_o <= 1'b0;
`ifdef SIM_CTRL_STATS_EN
      tick_cnt  <= '0;
`endif
    end else begin
      case (state)
        S_HOLD: begin
          tick_o   <= '0;
          hold_cnt <= hold_cnt + HOLD_W'(1);
          if (hold_cnt == HOLD_W'(RST_HOLD - 1)) begin
            rst_out_n <= 1'b1;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          cyc_cnt_o <= cyc_cnt_o + TIMEOUT_W'(1);
          ch_cnt    <= ch_cnt_nxt;
          wd_cnt    <= kick ? '0 : wd_inc;
          // Terminating edge drops ticks so tick_o is never high outside RUN.
          if (done_i) begin
            state  <= S_DONE;
            done_o <= 1'b1;
            tick_o <= '0;
          end else if (wd_expire) begin
            state     <= S_TIMEOUT;
            timeout_o <= 1'b1;
            tick_o    <= '0;
          end else begin
            tick_o <= tick_nxt;
`ifdef SIM_CTRL_STATS_EN
            for (int i = 0; i < NUM_CH; i++) begin
              if (tick_nxt[i] && (tick_cnt[i] != 16'hFFFF)) begin
                tick_cnt[i] <= tick_cnt[i] + 16'd1;
              end
            end
`endif
          end
        end
        default: begin
          tick_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sim_ctrl_gen.sv
// Scoreboard bench for sim_ctrl_gen: expectations queued before each edge, popped and compared after.
// Statistics checks compile in only when SIM_CTRL_STATS_EN is defined.
module tb_sim_ctrl_gen;
  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned DIV_W     = 8;
  localparam int unsigned RST_HOLD  = 16;
  localparam int unsigned TIMEOUT_W = 32;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NUM_CH*DIV_W-1:0] div_cfg = '0;
  logic [NUM_CH-1:0]       ch_en = '0;
  logic                    kick = 1'b0;
  logic                    done_i = 1'b0;
  logic [TIMEOUT_W-1:0]    timeout_lim = '0;
  logic                    rst_out_n;
  logic [NUM_CH-1:0]       tick_o;
  logic [1:0]              state_o;
  logic [TIMEOUT_W-1:0]    cyc_cnt_o;
  logic                    done_o;
  logic                    timeout_o;
`ifdef SIM_CTRL_STATS_EN
  logic [NUM_CH*16-1:0]    tick_cnt_o;
`endif

  always #5 clk = ~clk;

  sim_ctrl_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .RST_HOLD(RST_HOLD), .TIMEOUT_W(TIMEOUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .div_cfg(div_cfg), .ch_en(ch_en), .kick(kick), .done_i(done_i),
    .timeout_lim(timeout_lim), .rst_out_n(rst_out_n), .tick_o(tick_o), .state_o(state_o),
    .cyc_cnt_o(cyc_cnt_o), .done_o(done_o),
`ifdef SIM_CTRL_STATS_EN
    .tick_cnt_o(tick_cnt_o),
`endif
    .timeout_o(timeout_o)
  );

  typedef struct packed {
    logic [1:0]           st;
    logic                 ro;
    logic                 dn;
    logic                 to;
    logic [NUM_CH-1:0]    tk;
    logic [TIMEOUT_W-1:0] cyc;
  } obs_t;

  int   vectors = 0;
  int   miscompares = 0;
  obs_t exp_q[$];

  function automatic obs_t observe();
    observe = '{st: state_o, ro: rst_out_n, dn: done_o, to: timeout_o, tk: tick_o, cyc: cyc_cnt_o};
  endfunction

  function automatic obs_t mk(input int st, input bit ro, input bit dn, input bit to,
                              input logic [NUM_CH-1:0] tk, input int cyc);
    mk = '{st: 2'(st), ro: ro, dn: dn, to: to, tk: tk, cyc: TIMEOUT_W'(cyc)};
  endfunction

  // Reset, release, and wait (bounded) until the DUT reaches RUN; leaves us just after RUN entry.
  task automatic go_run();
    int n;
    @(negedge clk);
    rst_n = 1'b0; kick = 1'b0; done_i = 1'b0; ch_en = '0;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (state_o !== 2'd1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (state_o !== 2'd1) begin
      miscompares++;
      $display("FAIL go_run: state_o=%0d required 1", state_o);
    end
  endtask

  task automatic test_reset();
    obs_t e, g;
    @(negedge clk);
    rst_n = 1'b0; ch_en = '1; div_cfg = '0; kick = 1'b1; done_i = 1'b0; timeout_lim = 32'd3;
    #1;
    exp_q.push_back(mk(0, 0, 0, 0, '0, 0));
    e = exp_q.pop_front(); g = observe(); vectors++;
    if (g !== e) begin miscompares++; $display("FAIL reset_values: got %h required %h", g, e); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= int'(RST_HOLD); k++) begin
      exp_q.push_back(mk((k == int'(RST_HOLD)) ? 1 : 0, k == int'(RST_HOLD), 0, 0, '0, 0));
      @(negedge clk);
      e = exp_q.pop_front(); g = observe(); vectors++;
      if (g !== e) begin miscompares++; $display("FAIL hold_release edge %0d: got %h required %h", k, g, e); end
    end
    ch_en = '0; kick = 1'b0; timeout_lim = '0;
  endtask

  task automatic test_ticks();
    obs_t e, g;
    int k0, k1, rc;
    logic [NUM_CH-1:0] tk;
    go_run();
    timeout_lim = '0;
    div_cfg = {8'd0, 8'd10, 8'd0, 8'd3};
    ch_en = 4'b0011;
    k0 = 0; k1 = 0; rc = 0;
    for (int c = 0; c < 26; c++) begin
      if (c == 14) ch_en[0] = 1'b0;
      if (c == 17) ch_en[0] = 1'b1;
      tk = '0;
      if (ch_en[0]) begin k0++; tk[0] = (k0 % 4 == 0); end else k0 = 0;
      k1++; tk[1] = 1'b1;
      rc++;
      exp_q.push_back(mk(1, 1, 0, 0, tk, rc));
      @(negedge clk);
      e = exp_q.pop_front(); g = observe(); vectors++;
      if (g !== e) begin miscompares++; $display("FAIL ticks_div3_div0 cycle %0d: got %h required %h", c, g, e); end
    end
    // ch2 counts toward 10, then its divider is lowered below the running count.
    ch_en = 4'b0100;
    for (int c = 0; c < 13; c++) begin
      if (c == 6) div_cfg[2*DIV_W +: DIV_W] = 8'd2;
      tk = '0;
      tk[2] = (c >= 6) && ((c - 6) % 3 == 0);
      rc++;
      exp_q.push_back(mk(1, 1, 0, 0, tk, rc));
      @(negedge clk);
      e = exp_q.pop_front(); g = observe(); vectors++;
      if (g !== e) begin miscompares++; $display("FAIL ticks_div_lowered cycle %0d: got %h required %h", c, g, e); end
    end
  endtask

  task automatic test_watchdog();
    obs_t e, g;
    // Plain expiry with a ticking channel, which must stop on timeout.
    go_run();
    div_cfg = '0; ch_en = 4'b0010; timeout_lim = 32'd100;
    for (int n = 1; n <= 105; n++) begin
      kick = (n == 102);
      exp_q.push_back(mk((n < 100) ? 1 : 3, 1, 0, n >= 100, (n < 100) ? 4'b0010 : 4'b0000, (n < 100) ? n : 100));
      @(negedge clk);
      e = exp_q.pop_front(); g = observe(); vectors++;
      if (g !== e) begin miscompares++; $display("FAIL wd_100 cycle %0d: got %h required %h", n, g, e); end
    end
    // Kick on RUN cycle 50 pushes expiry to cycle 150.
    go_run();
    ch_en = '0; timeout_lim = 32'd100;
    for (int n = 1; n <= 153; n++) begin
      kick = (n == 50);
      exp_q.push_back(mk((n < 150) ? 1 : 3, 1, 0, n >= 150, '0, (n < 150) ? n : 150));
      @(negedge clk);
      e = exp_q.pop_front(); g = observe(); vectors++;
      if (g !== e) begin miscompares++; $display("FAIL wd_kick cycle %0d: got %h required %h", n, g, e); end
    end
    kick = 1'b0;
    // Limit 0 disables the watchdog.
    go_run();
    timeout_lim = '0;
    for (int n = 1; n <= 300; n++) begin
      exp_q.push_back(mk(1, 1, 0, 0, '0, n));
      @(negedge clk);
      e = exp_q.pop_front(); g = observe(); vectors++;
      if (g !== e) begin miscompares++; $display("FAIL wd_off cycle %0d: got %h required %h", n, g, e); end
    end
    // Smallest limit expires on the first RUN cycle.
    go_run();
    timeout_lim = 32'd1;
    exp_q.push_back(mk(3, 1, 0, 1, '0, 1));
    @(negedge clk);
    e = exp_q.pop_front(); g = observe(); vectors++;
    if (g !== e) begin miscompares++; $display("FAIL wd_lim1: got %h required %h", g, e); end
  endtask

  task automatic test_done_vs_timeout();
    obs_t e, g;
    go_run();
    div_cfg = '0; ch_en = 4'b0010; timeout_lim = 32'd20;
    for (int n = 1; n <= 25; n++) begin
      done_i = (n == 20) || (n == 22);
      kick = (n == 23);
      exp_q.push_back(mk((n < 20) ? 1 : 2, 1, n >= 20, 0, (n < 20) ? 4'b0010 : 4'b0000, (n < 20) ? n : 20));
      @(negedge clk);
      e = exp_q.pop_front(); g = observe(); vectors++;
      if (g !== e) begin miscompares++; $display("FAIL done_vs_timeout cycle %0d: got %h required %h", n, g, e); end
    end
    done_i = 1'b0; kick = 1'b0; timeout_lim = '0;
  endtask

  task automatic test_midrun_reset();
    obs_t e, g;
    go_run();
    div_cfg = {8'd0, 8'd0, 8'd0, 8'd3}; ch_en = 4'b0011; timeout_lim = '0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(mk(0, 0, 0, 0, '0, 0));
    e = exp_q.pop_front(); g = observe(); vectors++;
    if (g !== e) begin miscompares++; $display("FAIL midrun_async_reset: got %h required %h", g, e); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= int'(RST_HOLD); k++) begin
      exp_q.push_back(mk((k == int'(RST_HOLD)) ? 1 : 0, k == int'(RST_HOLD), 0, 0, '0, 0));
      @(negedge clk);
      e = exp_q.pop_front(); g = observe(); vectors++;
      if (g !== e) begin miscompares++; $display("FAIL midrun_rehold edge %0d: got %h required %h", k, g, e); end
    end
    exp_q.push_back(mk(1, 1, 0, 0, 4'b0010, 1));
    @(negedge clk);
    e = exp_q.pop_front(); g = observe(); vectors++;
    if (g !== e) begin miscompares++; $display("FAIL midrun_first_run: got %h required %h", g, e); end
  endtask

`ifdef SIM_CTRL_STATS_EN
  task automatic test_stats();
    logic [15:0] ecnt_q[$];
    logic [15:0] ec;
    go_run();
    div_cfg = '0; ch_en = 4'b0001; timeout_lim = '0;
    ecnt_q.push_back(16'd100);
    repeat (100) @(negedge clk);
    ec = ecnt_q.pop_front(); vectors++;
    if (tick_cnt_o[15:0] !== ec) begin miscompares++; $display("FAIL stats_ch0_100: got %h required %h", tick_cnt_o[15:0], ec); end
    ecnt_q.push_back(16'hFFFF);
    ecnt_q.push_back(16'h0000);
    repeat (69900) @(negedge clk);
    ec = ecnt_q.pop_front(); vectors++;
    if (tick_cnt_o[15:0] !== ec) begin miscompares++; $display("FAIL stats_ch0_sat: got %h required %h", tick_cnt_o[15:0], ec); end
    ec = ecnt_q.pop_front(); vectors++;
    if (tick_cnt_o[31:16] !== ec) begin miscompares++; $display("FAIL stats_ch1_idle: got %h required %h", tick_cnt_o[31:16], ec); end
  endtask
`endif

  initial begin
    #5000000;
    $display("FAIL global_time_limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ticks();
    test_watchdog();
    test_done_vs_timeout();
    test_midrun_reset();
`ifdef SIM_CTRL_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
